// File: rtl/adder_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share a single adder, one operation
// in flight at a time, with a done timeout and one-hot response routing.
module adder_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16,
  localparam int IDW    = $clog2(NREQ),
  localparam int CW     = $clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_valid,
  input  logic [WIDTH:0]        add_sum,
  input  logic                  add_done,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH:0]        rsp_sum,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [IDW:0]  NREQ_W   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);
  // Counter value in the last ISSUE/WAIT cycle before the operation is abandoned.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  rot;
  logic [IDW-1:0]   off;
  logic [IDW:0]     sum_idx;
  logic [IDW-1:0]   win_idx;
  logic             win_vld;

  // Rotate the request vector so bit 0 is the requester at ptr, pick the lowest set
  // bit, then map the offset back to an absolute index modulo NREQ.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default first,
    // so no path through the block leaves it unassigned and no latch is inferred.
    rot     = NREQ'({req_valid, req_valid} >> ptr_q);
    win_vld = |rot;
    off     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (rot[k]) off = IDW'(k);
    end
    sum_idx = {1'b0, ptr_q} + {1'b0, off};
    if (sum_idx >= NREQ_W) sum_idx = sum_idx - NREQ_W;
    win_idx = sum_idx[IDW-1:0];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_ISSUE;
          a_d     = req_a[int'(win_idx)*WIDTH +: WIDTH];
          b_d     = req_b[int'(win_idx)*WIDTH +: WIDTH];
          gid_d   = win_idx;
          cnt_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (add_done) begin
          state_d = S_RESP;
          sum_d   = add_sum;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          sum_d   = '0;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ptr_d   = (gid_q == LAST_ID) ? '0 : gid_q + IDW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == S_IDLE && win_vld) req_ready[win_idx] = 1'b1;
    if (state_q == S_RESP) rsp_valid[gid_q] = 1'b1;
  end

  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_valid = (state_q == S_ISSUE);
  assign rsp_sum   = (state_q == S_RESP) ? sum_q : '0;
  assign rsp_err   = (state_q == S_RESP) ? err_q : 1'b0;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: single request, carry, zero-latency and spurious
// done, timeout, round-robin fairness and reset in the middle of an operation.
module tb_adder_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [7:0]  add_a, add_b;
  logic        add_valid;
  logic [8:0]  add_sum;
  logic        add_done;
  logic [3:0]  rsp_valid;
  logic [8:0]  rsp_sum;
  logic        rsp_err, busy;
  logic [1:0]  grant_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_sum(add_sum), .add_done(add_done),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request, wait (bounded) for ready, pass the accept edge, withdraw.
  task automatic do_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]          = 1'b1;
    req_a[i*8 +: 8]       = a;
    req_b[i*8 +: 8]       = b;
    #1;
    for (int n = 0; n < 20 && !req_ready[i]; n++) cyc();
    check($sformatf("ready_req%0d", i), 32'(req_ready), 32'(4'b0001 << i));
    cyc();
    req_valid[i] = 1'b0;
  endtask

  // Adder stand-in: called at the first negedge after the accept edge (ISSUE).
  // Raises done k cycles after add_valid unless hang; returns at the RESP cycle.
  task automatic serve(input int k, input bit hang, input logic [8:0] s,
                       output int n, output int pulses,
                       output logic [7:0] aa, output logic [7:0] bb);
    n      = 1;
    pulses = 0;
    aa     = add_a;
    bb     = add_b;
    while (rsp_valid == 4'b0 && n < 40) begin
      if (add_valid) pulses++;
      add_done = !hang && (n - 1 == k);
      add_sum  = add_done ? s : 9'h000;
      cyc();
      n++;
    end
    add_done = 1'b0;
    add_sum  = 9'h000;
  endtask

  initial begin
    int n, p;
    logic [7:0] aa, bb;
    int e;

    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; add_sum = '0; add_done = 1'b0;
    #12;
    check("rst_ready",    32'(req_ready), 32'h0);
    check("rst_add_a",    32'(add_a),     32'h0);
    check("rst_add_b",    32'(add_b),     32'h0);
    check("rst_add_vld",  32'(add_valid), 32'h0);
    check("rst_rsp_vld",  32'(rsp_valid), 32'h0);
    check("rst_rsp_sum",  32'(rsp_sum),   32'h0);
    check("rst_rsp_err",  32'(rsp_err),   32'h0);
    check("rst_busy",     32'(busy),      32'h0);
    check("rst_gid",      32'(grant_id),  32'h0);
    req_valid = 4'b0110;
    #1;
    check("rst_ready_ptr0", 32'(req_ready), 32'h2);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // Single request, requester 1, done one cycle after add_valid.
    do_req(1, 8'h7F, 8'h01);
    check("single_busy_issue", 32'(busy), 32'h1);
    serve(1, 1'b0, 9'h080, n, p, aa, bb);
    check("single_latency", 32'(n),         32'd3);
    check("single_rsp_vld", 32'(rsp_valid), 32'h2);
    check("single_rsp_sum", 32'(rsp_sum),   32'h080);
    check("single_rsp_err", 32'(rsp_err),   32'h0);
    check("single_pulses",  32'(p),         32'd1);
    check("single_add_a",   32'(aa),        32'h7F);
    check("single_add_b",   32'(bb),        32'h01);
    check("single_add_a_resp", 32'(add_a),  32'h7F);
    check("single_gid",     32'(grant_id),  32'h1);
    check("single_busy_resp", 32'(busy),    32'h1);
    cyc();
    check("single_busy_idle", 32'(busy),    32'h0);
    check("single_rsp_gone",  32'(rsp_valid), 32'h0);

    // Carry-out passes through in bit WIDTH; done two cycles after add_valid.
    do_req(0, 8'hFF, 8'hFF);
    serve(2, 1'b0, 9'h1FE, n, p, aa, bb);
    check("carry_latency", 32'(n),         32'd4);
    check("carry_rsp_vld", 32'(rsp_valid), 32'h1);
    check("carry_rsp_sum", 32'(rsp_sum),   32'h1FE);
    check("carry_rsp_err", 32'(rsp_err),   32'h0);
    cyc();

    // Spurious done in IDLE is ignored.
    add_done = 1'b1;
    add_sum  = 9'h155;
    cyc();
    add_done = 1'b0;
    add_sum  = 9'h000;
    check("spur_busy",    32'(busy),      32'h0);
    check("spur_rsp_vld", 32'(rsp_valid), 32'h0);
    check("spur_add_vld", 32'(add_valid), 32'h0);
    cyc();
    check("spur_rsp_vld2", 32'(rsp_valid), 32'h0);

    // Zero-latency adder: done in the ISSUE cycle.
    do_req(2, 8'h10, 8'h20);
    serve(0, 1'b0, 9'h030, n, p, aa, bb);
    check("zero_latency", 32'(n),         32'd2);
    check("zero_rsp_vld", 32'(rsp_valid), 32'h4);
    check("zero_rsp_sum", 32'(rsp_sum),   32'h030);
    check("zero_pulses",  32'(p),         32'd1);
    cyc();

    // Timeout: adder never answers.
    do_req(3, 8'h05, 8'h06);
    serve(0, 1'b1, 9'h000, n, p, aa, bb);
    check("to_latency", 32'(n),         32'(TIMEOUT + 1));
    check("to_rsp_vld", 32'(rsp_valid), 32'h8);
    check("to_rsp_sum", 32'(rsp_sum),   32'h000);
    check("to_rsp_err", 32'(rsp_err),   32'h1);
    check("to_pulses",  32'(p),         32'd1);
    cyc();
    do_req(1, 8'h01, 8'h02);
    serve(1, 1'b0, 9'h003, n, p, aa, bb);
    check("after_to_latency", 32'(n),         32'd3);
    check("after_to_rsp_vld", 32'(rsp_valid), 32'h2);
    check("after_to_rsp_sum", 32'(rsp_sum),   32'h003);
    check("after_to_rsp_err", 32'(rsp_err),   32'h0);
    cyc();

    // Fairness: all requesters valid from reset release.
    rst = 1'b0;
    req_valid = 4'hF;
    req_a = {8'h40, 8'h30, 8'h20, 8'h10};
    req_b = {8'h04, 8'h03, 8'h02, 8'h01};
    cyc();
    rst = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      e = j % 4;
      check($sformatf("fair_ready_%0d", j), 32'(req_ready), 32'(4'b0001 << e));
      cyc();
      check($sformatf("fair_gid_%0d", j), 32'(grant_id), 32'(e));
      serve(0, 1'b0, 9'(8'h11 * (e + 1)), n, p, aa, bb);
      check($sformatf("fair_add_a_%0d", j), 32'(aa),        32'(8'h10 * (e + 1)));
      check($sformatf("fair_rsp_%0d", j),   32'(rsp_valid), 32'(4'b0001 << e));
      check($sformatf("fair_sum_%0d", j),   32'(rsp_sum),   32'(8'h11 * (e + 1)));
      cyc();
    end
    req_valid = '0;
    cyc();

    // Reset in WAIT for requester 2; the operation must vanish.
    do_req(2, 8'h11, 8'h22);
    cyc();
    cyc();
    check("mid_busy_wait", 32'(busy), 32'h1);
    req_valid = 4'b1100;
    rst = 1'b0;
    #1;
    check("mid_add_a",   32'(add_a),     32'h0);
    check("mid_add_b",   32'(add_b),     32'h0);
    check("mid_add_vld", 32'(add_valid), 32'h0);
    check("mid_busy",    32'(busy),      32'h0);
    check("mid_rsp_vld", 32'(rsp_valid), 32'h0);
    check("mid_rsp_sum", 32'(rsp_sum),   32'h0);
    check("mid_rsp_err", 32'(rsp_err),   32'h0);
    check("mid_gid",     32'(grant_id),  32'h0);
    check("mid_ready",   32'(req_ready), 32'h4);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      cyc();
      check($sformatf("mid_no_rsp_%0d", j), 32'(rsp_valid), 32'h0);
    end
    rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h4);
    cyc();
    check("post_rst_gid",  32'(grant_id), 32'h2);
    check("post_rst_busy", 32'(busy),     32'h1);
    req_valid[2] = 1'b0;
    serve(1, 1'b0, 9'h033, n, p, aa, bb);
    check("post_rst_latency", 32'(n),         32'd3);
    check("post_rst_rsp_vld", 32'(rsp_valid), 32'h4);
    check("post_rst_rsp_sum", 32'(rsp_sum),   32'h033);
    check("post_rst_add_a",   32'(aa),        32'h11);
    cyc();
    check("post_rst_next_ready", 32'(req_ready), 32'h8);
    req_valid = '0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
